// File: rtl/uart_host_stream_if.sv
// Host-side initiator that bridges valid/ready byte streams onto the UART core's parallel strobes.
// Optional overflow-edge counter is built only when UART_HOST_OVF_CNT_EN is defined.
module uart_host_stream_if #(
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] TXD_DATA,
  input  logic       TXD_VALID,
  output logic       TXD_READY,
  output logic [7:0] RXD_DATA,
  output logic [1:0] RXD_ERR,
  output logic       RXD_VALID,
  input  logic       RXD_READY,
  output logic       UART_CSN,
  output logic       UART_WEN,
  output logic       UART_OEN,
  output logic [7:0] UART_DATA_IN,
  input  logic [7:0] UART_DATA_OUT,
  input  logic       UART_TXRDY,
  input  logic       UART_RXRDY,
  input  logic       UART_PARITY_ERR,
  input  logic       UART_FRAMING_ERR,
  input  logic       UART_OVERFLOW,
  output logic [7:0] OVF_CNT
);

  localparam logic [2:0] GUARD_LOAD = 3'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, GUARD} state_t;

  state_t     state;
  logic [2:0] guard_cnt;
  logic       last_rx;
  logic       tx_req;
  logic       rx_req;
  logic       serve_tx;
  logic       serve_rx;

  // Round-robin between the two sides only when both want the UART in the same IDLE cycle
  always_comb begin
    tx_req    = TXD_VALID & UART_TXRDY;
    rx_req    = UART_RXRDY & ~RXD_VALID;
    serve_rx  = (state == IDLE) & rx_req & (~tx_req | ~last_rx);
    serve_tx  = (state == IDLE) & tx_req & (~rx_req | last_rx);
    TXD_READY = RESET_N & serve_tx;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state        <= IDLE;
      guard_cnt    <= 3'd0;
      last_rx      <= 1'b0;
      UART_CSN     <= 1'b1;
      UART_WEN     <= 1'b1;
      UART_OEN     <= 1'b1;
      UART_DATA_IN <= 8'h00;
      RXD_VALID    <= 1'b0;
      RXD_DATA     <= 8'h00;
      RXD_ERR      <= 2'b00;
    end else begin
      UART_CSN <= 1'b1;
      UART_WEN <= 1'b1;
      UART_OEN <= 1'b1;
      if (RXD_VALID && RXD_READY)
        RXD_VALID <= 1'b0;

      case (state)
        IDLE: begin
          if (serve_rx) begin
            state    <= READ;
            last_rx  <= 1'b1;
            UART_CSN <= 1'b0;
            UART_OEN <= 1'b0;
          end else if (serve_tx) begin
            state        <= WRITE;
            last_rx      <= 1'b0;
            UART_CSN     <= 1'b0;
            UART_WEN     <= 1'b0;
            UART_DATA_IN <= TXD_DATA;
          end
        end
        WRITE: begin
          state     <= GUARD;
          guard_cnt <= GUARD_LOAD;
        end
        READ: begin
          RXD_DATA  <= UART_DATA_OUT;
          RXD_ERR   <= {UART_FRAMING_ERR, UART_PARITY_ERR};
          RXD_VALID <= 1'b1;
          state     <= GUARD;
          guard_cnt <= GUARD_LOAD;
        end
        GUARD: begin
          // Give the UART time to drop TXRDY/RXRDY before they are trusted again
          if (guard_cnt == 3'd0)
            state <= IDLE;
          else
            guard_cnt <= guard_cnt - 3'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_HOST_OVF_CNT_EN
  logic       ovf_prev;
  logic [7:0] ovf_cnt;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      ovf_prev <= 1'b0;
      ovf_cnt  <= 8'h00;
    end else begin
      ovf_prev <= UART_OVERFLOW;
      if (UART_OVERFLOW && !ovf_prev && (ovf_cnt != 8'hFF))
        ovf_cnt <= ovf_cnt + 8'h01;
    end
  end

  assign OVF_CNT = ovf_cnt;
`else
  logic unused_ovf;
  assign unused_ovf = UART_OVERFLOW;
  assign OVF_CNT    = 8'h00;
`endif

endmodule

// File: tb/tb_uart_host_stream_if.sv
// Self-checking bench for uart_host_stream_if: a queue-based UART/stream model drives the DUT
// and the scenario tasks compare observed strobes and stream traffic against it.
module tb_uart_host_stream_if;

  localparam int G = 2;
`ifdef UART_HOST_OVF_CNT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       CLK;
  logic       RESET_N;
  logic [7:0] TXD_DATA;
  logic       TXD_VALID;
  logic       TXD_READY;
  logic [7:0] RXD_DATA;
  logic [1:0] RXD_ERR;
  logic       RXD_VALID;
  logic       RXD_READY;
  logic       UART_CSN, UART_WEN, UART_OEN;
  logic [7:0] UART_DATA_IN;
  logic [7:0] UART_DATA_OUT;
  logic       UART_TXRDY, UART_RXRDY, UART_PARITY_ERR, UART_FRAMING_ERR, UART_OVERFLOW;
  logic [7:0] OVF_CNT;

  uart_host_stream_if #(.GUARD_CYCLES(G)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .TXD_DATA(TXD_DATA), .TXD_VALID(TXD_VALID), .TXD_READY(TXD_READY),
    .RXD_DATA(RXD_DATA), .RXD_ERR(RXD_ERR), .RXD_VALID(RXD_VALID), .RXD_READY(RXD_READY),
    .UART_CSN(UART_CSN), .UART_WEN(UART_WEN), .UART_OEN(UART_OEN),
    .UART_DATA_IN(UART_DATA_IN), .UART_DATA_OUT(UART_DATA_OUT),
    .UART_TXRDY(UART_TXRDY), .UART_RXRDY(UART_RXRDY),
    .UART_PARITY_ERR(UART_PARITY_ERR), .UART_FRAMING_ERR(UART_FRAMING_ERR),
    .UART_OVERFLOW(UART_OVERFLOW), .OVF_CNT(OVF_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp, n_fail, cyc;
  int txrdy_pct, rxrdy_pct;
  bit pending_pop;
  logic rst_n_drv, ovf_drv;

  logic [7:0] tx_src[$];
  logic [9:0] uart_rx_q[$];
  logic [7:0] wr_log[$];
  logic [9:0] rx_got[$];
  int         ev_kind[$];
  int         ev_cyc[$];
  int         hs_cyc[$];

  // One clock of the environment: observe registered strobes, then drive inputs, then note handshakes
  task automatic tick();
    @(negedge CLK);
    cyc++;
    if (pending_pop) begin
      if (uart_rx_q.size() > 0) void'(uart_rx_q.pop_front());
      pending_pop = 1'b0;
    end
    if (!UART_CSN && !UART_WEN) begin
      wr_log.push_back(UART_DATA_IN); ev_kind.push_back(0); ev_cyc.push_back(cyc);
    end
    if (!UART_CSN && !UART_OEN) begin
      ev_kind.push_back(1); ev_cyc.push_back(cyc); pending_pop = 1'b1;
    end
    RESET_N    = rst_n_drv;
    TXD_VALID  = (tx_src.size() > 0);
    TXD_DATA   = (tx_src.size() > 0) ? tx_src[0] : 8'h00;
    UART_TXRDY = (int'($urandom_range(0, 99)) < txrdy_pct);
    UART_RXRDY = (uart_rx_q.size() > 0);
    {UART_FRAMING_ERR, UART_PARITY_ERR, UART_DATA_OUT} = (uart_rx_q.size() > 0) ? uart_rx_q[0] : 10'h000;
    RXD_READY  = (int'($urandom_range(0, 99)) < rxrdy_pct);
    UART_OVERFLOW = ovf_drv;
    #1;
    if (TXD_VALID && TXD_READY) begin
      hs_cyc.push_back(cyc);
      if (tx_src.size() > 0) void'(tx_src.pop_front());
    end
    if (RXD_VALID && RXD_READY) rx_got.push_back({RXD_ERR, RXD_DATA});
  endtask

  task automatic clear_logs();
    wr_log.delete(); rx_got.delete(); ev_kind.delete(); ev_cyc.delete(); hs_cyc.delete();
  endtask

  task automatic do_reset();
    rst_n_drv = 1'b0;
    tx_src.delete(); uart_rx_q.delete();
    pending_pop = 1'b0; ovf_drv = 1'b0;
    txrdy_pct = 100; rxrdy_pct = 100;
    repeat (3) tick();
  endtask

  task automatic release_reset();
    rst_n_drv = 1'b1;
    clear_logs();
  endtask

  function automatic int count_kind(int k);
    int n = 0;
    foreach (ev_kind[i]) if (ev_kind[i] == k) n++;
    return n;
  endfunction

  task automatic test_reset();
    do_reset();
    tx_src.push_back(8'h11);
    uart_rx_q.push_back(10'h0AA);
    repeat (2) tick();
    n_cmp++; if (UART_CSN !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_csn: got %b want 1", UART_CSN); end
    n_cmp++; if (UART_WEN !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_wen: got %b want 1", UART_WEN); end
    n_cmp++; if (UART_OEN !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_oen: got %b want 1", UART_OEN); end
    n_cmp++; if (UART_DATA_IN !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_data_in: got %h want 00", UART_DATA_IN); end
    n_cmp++; if (TXD_READY !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_txd_ready: got %b want 0", TXD_READY); end
    n_cmp++; if (RXD_VALID !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rxd_valid: got %b want 0", RXD_VALID); end
    n_cmp++; if (RXD_DATA !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_rxd_data: got %h want 00", RXD_DATA); end
    n_cmp++; if (RXD_ERR !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_rxd_err: got %b want 00", RXD_ERR); end
    n_cmp++; if (OVF_CNT !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_ovf_cnt: got %0d want 0", OVF_CNT); end
  endtask

  task automatic test_single_tx();
    logic [7:0] w0, w1;
    int d_strobe, d_hs;
    do_reset();
    tx_src.push_back(8'hA5);
    tx_src.push_back(8'hC3);
    tick();
    release_reset();
    repeat (16) tick();
    w0 = (wr_log.size() > 0) ? wr_log[0] : 8'h00;
    w1 = (wr_log.size() > 1) ? wr_log[1] : 8'h00;
    d_strobe = (ev_cyc.size() > 0 && hs_cyc.size() > 0) ? ev_cyc[0] - hs_cyc[0] : -1;
    d_hs     = (hs_cyc.size() > 1) ? hs_cyc[1] - hs_cyc[0] : -1;
    n_cmp++; if (wr_log.size() !== 2) begin n_fail++; $display("[TB] FAIL tx_write_count: got %0d want 2", wr_log.size()); end
    n_cmp++; if (w0 !== 8'hA5) begin n_fail++; $display("[TB] FAIL tx_data0: got %h want a5", w0); end
    n_cmp++; if (w1 !== 8'hC3) begin n_fail++; $display("[TB] FAIL tx_data1: got %h want c3", w1); end
    n_cmp++; if (hs_cyc.size() !== 2) begin n_fail++; $display("[TB] FAIL tx_handshakes: got %0d want 2", hs_cyc.size()); end
    n_cmp++; if (d_strobe !== 1) begin n_fail++; $display("[TB] FAIL tx_strobe_latency: got %0d want 1", d_strobe); end
    n_cmp++; if (d_hs !== 2 + G) begin n_fail++; $display("[TB] FAIL tx_byte_period: got %0d want %0d", d_hs, 2 + G); end
    n_cmp++; if (UART_DATA_IN !== 8'hC3) begin n_fail++; $display("[TB] FAIL tx_data_hold: got %h want c3", UART_DATA_IN); end
  endtask

  task automatic test_backpressure();
    logic [7:0] w0;
    do_reset();
    txrdy_pct = 0;
    tx_src.push_back(8'h3C);
    tick();
    release_reset();
    repeat (20) tick();
    n_cmp++; if (ev_cyc.size() !== 0) begin n_fail++; $display("[TB] FAIL bp_no_strobe: got %0d strobes want 0", ev_cyc.size()); end
    n_cmp++; if (hs_cyc.size() !== 0) begin n_fail++; $display("[TB] FAIL bp_no_ready: got %0d handshakes want 0", hs_cyc.size()); end
    txrdy_pct = 100;
    repeat (10) tick();
    w0 = (wr_log.size() > 0) ? wr_log[0] : 8'h00;
    n_cmp++; if (wr_log.size() !== 1) begin n_fail++; $display("[TB] FAIL bp_write_count: got %0d want 1", wr_log.size()); end
    n_cmp++; if (w0 !== 8'h3C) begin n_fail++; $display("[TB] FAIL bp_data: got %h want 3c", w0); end
  endtask

  task automatic test_rx_error();
    logic [9:0] r0, r1;
    do_reset();
    rxrdy_pct = 0;
    uart_rx_q.push_back({2'b01, 8'h5A});
    uart_rx_q.push_back({2'b00, 8'h77});
    tick();
    release_reset();
    repeat (15) tick();
    n_cmp++; if (count_kind(1) !== 1) begin n_fail++; $display("[TB] FAIL rx_held_reads: got %0d want 1", count_kind(1)); end
    n_cmp++; if (RXD_VALID !== 1'b1) begin n_fail++; $display("[TB] FAIL rx_valid_held: got %b want 1", RXD_VALID); end
    n_cmp++; if (RXD_DATA !== 8'h5A) begin n_fail++; $display("[TB] FAIL rx_data: got %h want 5a", RXD_DATA); end
    n_cmp++; if (RXD_ERR !== 2'b01) begin n_fail++; $display("[TB] FAIL rx_err: got %b want 01", RXD_ERR); end
    n_cmp++; if (rx_got.size() !== 0) begin n_fail++; $display("[TB] FAIL rx_no_handshake: got %0d want 0", rx_got.size()); end
    rxrdy_pct = 100;
    repeat (15) tick();
    r0 = (rx_got.size() > 0) ? rx_got[0] : 10'h000;
    r1 = (rx_got.size() > 1) ? rx_got[1] : 10'h000;
    n_cmp++; if (rx_got.size() !== 2) begin n_fail++; $display("[TB] FAIL rx_count: got %0d want 2", rx_got.size()); end
    n_cmp++; if (r0 !== {2'b01, 8'h5A}) begin n_fail++; $display("[TB] FAIL rx_byte0: got %h want 15a", r0); end
    n_cmp++; if (r1 !== {2'b00, 8'h77}) begin n_fail++; $display("[TB] FAIL rx_byte1: got %h want 077", r1); end
    n_cmp++; if (count_kind(1) !== 2) begin n_fail++; $display("[TB] FAIL rx_total_reads: got %0d want 2", count_kind(1)); end
  endtask

  task automatic test_arbitration();
    int order[4] = '{1, 0, 1, 0};
    int gap;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tx_src.push_back(8'(8'h10 + i));
      uart_rx_q.push_back(10'(10'h080 + i));
    end
    tick();
    release_reset();
    repeat (30) tick();
    for (int i = 0; i < 4; i++) begin
      int k = (ev_kind.size() > i) ? ev_kind[i] : -1;
      n_cmp++; if (k !== order[i]) begin n_fail++; $display("[TB] FAIL arb_order[%0d]: got %0d want %0d (1=read)", i, k, order[i]); end
    end
    gap = (ev_cyc.size() > 1) ? ev_cyc[1] - ev_cyc[0] : -1;
    n_cmp++; if (gap !== 2 + G) begin n_fail++; $display("[TB] FAIL arb_gap: got %0d want %0d", gap, 2 + G); end
  endtask

  task automatic test_random();
    localparam int N = 40;
    logic [7:0] tx_exp[$];
    logic [9:0] rx_exp[$];
    int t, min_gap;
    do_reset();
    for (int i = 0; i < N; i++) begin
      logic [7:0] b = 8'($urandom);
      logic [9:0] r = 10'($urandom);
      tx_src.push_back(b); tx_exp.push_back(b);
      uart_rx_q.push_back(r); rx_exp.push_back(r);
    end
    txrdy_pct = 70;
    rxrdy_pct = 50;
    tick();
    release_reset();
    t = 0;
    while ((wr_log.size() < N || rx_got.size() < N) && t < 4000) begin
      tick();
      t++;
    end
    n_cmp++; if (wr_log.size() !== N) begin n_fail++; $display("[TB] FAIL rand_tx_count: got %0d want %0d", wr_log.size(), N); end
    n_cmp++; if (rx_got.size() !== N) begin n_fail++; $display("[TB] FAIL rand_rx_count: got %0d want %0d", rx_got.size(), N); end
    for (int i = 0; i < N && i < wr_log.size(); i++) begin
      n_cmp++; if (wr_log[i] !== tx_exp[i]) begin n_fail++; $display("[TB] FAIL rand_tx[%0d]: got %h want %h", i, wr_log[i], tx_exp[i]); end
    end
    for (int i = 0; i < N && i < rx_got.size(); i++) begin
      n_cmp++; if (rx_got[i] !== rx_exp[i]) begin n_fail++; $display("[TB] FAIL rand_rx[%0d]: got %h want %h", i, rx_got[i], rx_exp[i]); end
    end
    min_gap = 1000;
    for (int i = 1; i < ev_cyc.size(); i++)
      if (ev_cyc[i] - ev_cyc[i-1] < min_gap) min_gap = ev_cyc[i] - ev_cyc[i-1];
    n_cmp++; if (min_gap < 2 + G) begin n_fail++; $display("[TB] FAIL rand_min_gap: got %0d want >= %0d", min_gap, 2 + G); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp10, exp_sat;
    do_reset();
    tick();
    release_reset();
    for (int i = 0; i < 10; i++) begin
      ovf_drv = 1'b1; tick(); tick();
      ovf_drv = 1'b0; tick();
    end
    repeat (2) tick();
    exp10 = OVF_EN ? 8'd10 : 8'd0;
    n_cmp++; if (OVF_CNT !== exp10) begin n_fail++; $display("[TB] FAIL ovf_10: got %0d want %0d", OVF_CNT, exp10); end
    for (int i = 0; i < 290; i++) begin
      ovf_drv = 1'b1; tick();
      ovf_drv = 1'b0; tick();
    end
    repeat (2) tick();
    exp_sat = OVF_EN ? 8'd255 : 8'd0;
    n_cmp++; if (OVF_CNT !== exp_sat) begin n_fail++; $display("[TB] FAIL ovf_sat: got %0d want %0d", OVF_CNT, exp_sat); end
  endtask

  task automatic test_reset_mid_write();
    int t;
    int d;
    logic [7:0] w0;
    do_reset();
    rxrdy_pct = 0;
    uart_rx_q.push_back({2'b00, 8'hE7});
    tx_src.push_back(8'h99);
    tick();
    release_reset();
    t = 0;
    while (wr_log.size() == 0 && t < 40) begin
      tick();
      t++;
    end
    n_cmp++; if (wr_log.size() !== 1) begin n_fail++; $display("[TB] FAIL mid_write_seen: got %0d want 1", wr_log.size()); end
    RESET_N = 1'b0;
    rst_n_drv = 1'b0;
    tick();
    n_cmp++; if (UART_CSN !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_csn: got %b want 1", UART_CSN); end
    n_cmp++; if (UART_WEN !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_wen: got %b want 1", UART_WEN); end
    n_cmp++; if (RXD_VALID !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rx_discard: got %b want 0", RXD_VALID); end
    n_cmp++; if (RXD_DATA !== 8'h00) begin n_fail++; $display("[TB] FAIL mid_rx_data: got %h want 00", RXD_DATA); end
    n_cmp++; if (UART_DATA_IN !== 8'h00) begin n_fail++; $display("[TB] FAIL mid_data_in: got %h want 00", UART_DATA_IN); end
    tx_src.delete();
    uart_rx_q.delete();
    tx_src.push_back(8'h42);
    tick();
    release_reset();
    repeat (6) tick();
    w0 = (wr_log.size() > 0) ? wr_log[0] : 8'h00;
    d  = (ev_cyc.size() > 0 && hs_cyc.size() > 0) ? ev_cyc[0] - hs_cyc[0] : -1;
    n_cmp++; if (w0 !== 8'h42) begin n_fail++; $display("[TB] FAIL mid_recover_data: got %h want 42", w0); end
    n_cmp++; if (d !== 1) begin n_fail++; $display("[TB] FAIL mid_recover_latency: got %0d want 1", d); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0;
    RESET_N = 1'b0; rst_n_drv = 1'b0;
    TXD_DATA = 8'h00; TXD_VALID = 1'b0; RXD_READY = 1'b0;
    UART_DATA_OUT = 8'h00; UART_TXRDY = 1'b0; UART_RXRDY = 1'b0;
    UART_PARITY_ERR = 1'b0; UART_FRAMING_ERR = 1'b0; UART_OVERFLOW = 1'b0;
    ovf_drv = 1'b0; pending_pop = 1'b0;
    txrdy_pct = 100; rxrdy_pct = 100;
    test_reset();
    test_single_tx();
    test_backpressure();
    test_rx_error();
    test_arbitration();
    test_random();
    test_overflow();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
